// File: rtl/elixirchip_es1_spu_ctl_pkg.sv
// Shared constants and helpers for the SPU control pipeline.
package elixirchip_es1_spu_ctl_pkg;

    localparam string USE_READY_TRUE  = "true";
    localparam string USE_READY_FALSE = "false";

    // Occupancy port width: enough to count LATENCY stages, never narrower than 1 bit.
    function automatic int occ_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_ctl_pipe_stage.sv
// One valid+payload register of the control pipeline; payload has no reset and
// only captures when a valid beat is loaded.
module elixirchip_es1_spu_ctl_pipe_stage #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic                 flush,
    input  logic                 adv,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data
);

    logic load;
    assign load = cke & adv & ~flush;

    always_ff @(posedge clk) begin
        if (reset || flush) valid <= 1'b0;
        else if (load)      valid <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (load && in_valid && !reset) data <= in_data;
    end

endmodule

// File: rtl/elixirchip_es1_spu_ctl_pipeline.sv
// Elastic register pipeline with bubble collapse, cke and flush.
// Optional occupancy counter: define ELIXIRCHIP_ES1_SPU_CTL_PIPE_OCCUPANCY_EN.
module elixirchip_es1_spu_ctl_pipeline
    import elixirchip_es1_spu_ctl_pkg::*;
#(
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 8,
    parameter string USE_READY  = "true",
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                          reset,
    input  logic                          clk,
    input  logic                          cke,
    input  logic                          flush,
    input  logic                          s_valid,
    input  logic [DATA_BITS-1:0]          s_data,
    output logic                          s_ready,
    output logic                          m_valid,
    output logic [DATA_BITS-1:0]          m_data,
    input  logic                          m_ready,
    output logic [occ_width(LATENCY)-1:0] occupancy
);

    localparam bit READY_EN = (USE_READY == USE_READY_TRUE);
    localparam int OCC_W    = occ_width(LATENCY);

    if (LATENCY < 0) begin : g_bad_latency
        $error("LATENCY must be >= 0");
    end
    if (DATA_BITS < 1) begin : g_bad_data_bits
        $error("DATA_BITS must be >= 1");
    end
    if (USE_READY != USE_READY_TRUE && USE_READY != USE_READY_FALSE) begin : g_bad_use_ready
        $error("USE_READY must be 'true' or 'false'");
    end
    if ((SIMULATION != "true" && SIMULATION != "false") ||
        (DEBUG != "true" && DEBUG != "false") || DEVICE == "") begin : g_bad_misc
        $error("SIMULATION and DEBUG must be 'true' or 'false', DEVICE non-empty");
    end

    logic out_adv;
    assign out_adv = READY_EN ? m_ready : 1'b1;

    if (LATENCY == 0) begin : g_bypass
        assign m_valid   = s_valid;
        assign m_data    = s_data;
        assign s_ready   = cke & out_adv;
        assign occupancy = '0;

        logic unused_ctl;
        assign unused_ctl = ^{clk, reset, flush};
    end else begin : g_pipe
        logic [LATENCY:0]                vld_pipe;
        logic [LATENCY:0][DATA_BITS-1:0] dat_pipe;
        logic [LATENCY+1:1]              adv;

        assign vld_pipe[0] = s_valid;
        assign dat_pipe[0] = s_data;

        // A stage may advance if it is empty or the stage ahead advances: bubbles collapse.
        always_comb begin
            adv            = '0;
            adv[LATENCY+1] = out_adv;
            for (int k = LATENCY; k >= 1; k--) adv[k] = ~vld_pipe[k] | adv[k+1];
        end

        for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
            elixirchip_es1_spu_ctl_pipe_stage #(
                .DATA_BITS (DATA_BITS)
            ) u_stage (
                .clk      (clk),
                .reset    (reset),
                .cke      (cke),
                .flush    (flush),
                .adv      (adv[k]),
                .in_valid (vld_pipe[k-1]),
                .in_data  (dat_pipe[k-1]),
                .valid    (vld_pipe[k]),
                .data     (dat_pipe[k])
            );
        end

        assign s_ready = cke & adv[1] & ~flush;
        assign m_valid = vld_pipe[LATENCY];
        assign m_data  = dat_pipe[LATENCY];

`ifdef ELIXIRCHIP_ES1_SPU_CTL_PIPE_OCCUPANCY_EN
        logic [OCC_W-1:0] occ_q;
        logic             in_xfer;
        logic             out_xfer;

        assign in_xfer  = s_valid & s_ready;
        assign out_xfer = cke & m_valid & adv[LATENCY+1];

        always_ff @(posedge clk) begin
            if (reset || flush)        occ_q <= '0;
            else if (in_xfer && !out_xfer) occ_q <= occ_q + OCC_W'(1);
            else if (out_xfer && !in_xfer) occ_q <= occ_q - OCC_W'(1);
        end

        assign occupancy = occ_q;
`else
        assign occupancy = '0;
`endif
    end

endmodule
